// File: rtl/rename_tag_ctrl_pkg.sv
// rename_tag_ctrl_pkg: shared types and constants for the rename tag allocator
// Provides the FSM state enum, the physical tag width, the no-tag flag bit
// index and a helper that builds the "no tag" slot encoding.
package rename_tag_ctrl_pkg;
    localparam int TAG_W      = 6;
    localparam int NO_TAG_BIT = 6;
    localparam int UTAG_W     = TAG_W + 1;
    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
    function automatic logic [UTAG_W-1:0] no_tag();
        logic [UTAG_W-1:0] t;
        t = '0;
        t[NO_TAG_BIT] = 1'b1;
        return t;
    endfunction
endpackage

// File: rtl/rename_tag_ctrl_tag_slot_compact.sv
// tag_slot_compact: per-slot prefix count of tag-needing valid uops
// Ports:
//   valid     - per-slot uop valid
//   needs_tag - per-slot "writes a register" flag
//   slot_need - valid & needs_tag per slot
//   slot_idx  - per slot, number of tag-needing slots below it (CW bits each)
//   need      - total number of tag-needing slots in the group
module tag_slot_compact #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]    valid,
    input  logic [N-1:0]    needs_tag,
    output logic [N-1:0]    slot_need,
    output logic [N*CW-1:0] slot_idx,
    output logic [CW-1:0]   need
);
    assign slot_need = valid & needs_tag;
    always_comb begin
        need     = '0;
        slot_idx = '0;
        for (int i = 0; i < N; i++) begin
            slot_idx[i*CW +: CW] = need;
            need = need + CW'(slot_need[i]);
        end
    end
endmodule

// File: rtl/rename_tag_ctrl.sv
// rename_tag_ctrl: all-or-nothing physical tag allocation for a rename group
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   IN_uopValid         - per-slot uop valid from decode
//   IN_uopNeedsTag      - per-slot destination-register flag
//   OUT_stall           - decode must hold its group this cycle
//   IN_issueTags        - free-list candidate tags, 6 bits each, lowest first
//   IN_issueTagsValid   - thermometer-coded candidate valid
//   OUT_issueValid      - consume candidate k this cycle
//   IN_mispr            - branch mispredict
//   IN_mispredFlush     - flush window after mispredict
//   OUT_uopValid        - registered renamed uop valid
//   OUT_uopTag          - registered per-slot tag, bit 6 = no tag
//   OUT_stallCnt        - saturating count of stalled RUN cycles
module rename_tag_ctrl
    import rename_tag_ctrl_pkg::*;
#(
    parameter int NUM_UOPS       = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_UOPS-1:0]        IN_uopValid,
    input  logic [NUM_UOPS-1:0]        IN_uopNeedsTag,
    output logic                       OUT_stall,
    input  logic [NUM_UOPS*TAG_W-1:0]  IN_issueTags,
    input  logic [NUM_UOPS-1:0]        IN_issueTagsValid,
    output logic [NUM_UOPS-1:0]        OUT_issueValid,
    input  logic                       IN_mispr,
    input  logic                       IN_mispredFlush,
    output logic [NUM_UOPS-1:0]        OUT_uopValid,
    output logic [NUM_UOPS*UTAG_W-1:0] OUT_uopTag,
    output logic [15:0]                OUT_stallCnt
);
    localparam int CW = $clog2(NUM_UOPS + 1);
    localparam int RW = (RECOVER_CYCLES < 1) ? 1 : $clog2(RECOVER_CYCLES + 1);

    state_t                     state;
    logic [RW-1:0]              rec_cnt;
    logic [15:0]                stall_cnt;
    logic [NUM_UOPS-1:0]        slot_need;
    logic [NUM_UOPS*CW-1:0]     slot_idx;
    logic [CW-1:0]              need;
    logic [NUM_UOPS-1:0]        issue_mask;
    logic                       tags_ok;
    logic                       grant;
    logic [NUM_UOPS*UTAG_W-1:0] tag_next;

    tag_slot_compact #(.N(NUM_UOPS), .CW(CW)) u_compact (
        .valid     (IN_uopValid),
        .needs_tag (IN_uopNeedsTag),
        .slot_need (slot_need),
        .slot_idx  (slot_idx),
        .need      (need)
    );

    // Candidates are thermometer-coded, so checking every k < need is the
    // same as checking candidate need-1 alone, without an out-of-range index.
    always_comb begin
        issue_mask = '0;
        tag_next   = '0;
        for (int k = 0; k < NUM_UOPS; k++)
            issue_mask[k] = CW'(k) < need;
        for (int i = 0; i < NUM_UOPS; i++)
            tag_next[i*UTAG_W +: UTAG_W] = slot_need[i]
                ? {1'b0, IN_issueTags[int'(slot_idx[i*CW +: CW])*TAG_W +: TAG_W]}
                : no_tag();
    end

    assign tags_ok        = (IN_issueTagsValid & issue_mask) == issue_mask;
    assign grant          = !rst && state == RUN && !IN_mispr && !IN_mispredFlush && tags_ok;
    assign OUT_issueValid = grant ? issue_mask : '0;
    assign OUT_stall      = state != RUN || (|IN_uopValid && !grant);
    assign OUT_stallCnt   = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            rec_cnt      <= '0;
            OUT_uopValid <= '0;
            OUT_uopTag   <= {NUM_UOPS{no_tag()}};
            stall_cnt    <= '0;
        end else begin
            OUT_uopValid <= grant ? IN_uopValid : '0;
            if (grant)
                OUT_uopTag <= tag_next;
            if (state == RUN && OUT_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (IN_mispr) begin
                state   <= FLUSH;
                rec_cnt <= '0;
            end else begin
                case (state)
                    FLUSH: if (!IN_mispredFlush) begin
                        state   <= (RECOVER_CYCLES == 0) ? RUN : RECOVER;
                        rec_cnt <= RW'(RECOVER_CYCLES);
                    end
                    RECOVER: if (rec_cnt <= RW'(1)) begin
                        state   <= RUN;
                        rec_cnt <= '0;
                    end else begin
                        rec_cnt <= rec_cnt - RW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rename_tag_ctrl.sv
// tb_rename_tag_ctrl: directed self-checking bench for rename_tag_ctrl
module tb_rename_tag_ctrl;
    logic        clk;
    logic        rst;
    logic [3:0]  valid, needs, tv, iv, uv;
    logic [23:0] tags;
    logic        mispr, mflush, stall;
    logic [27:0] ut;
    logic [15:0] scnt;
    int          checks, fails;

    rename_tag_ctrl #(.NUM_UOPS(4), .RECOVER_CYCLES(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .IN_uopValid       (valid),
        .IN_uopNeedsTag    (needs),
        .OUT_stall         (stall),
        .IN_issueTags      (tags),
        .IN_issueTagsValid (tv),
        .OUT_issueValid    (iv),
        .IN_mispr          (mispr),
        .IN_mispredFlush   (mflush),
        .OUT_uopValid      (uv),
        .OUT_uopTag        (ut),
        .OUT_stallCnt      (scnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] n, input logic [3:0] t,
                         input logic m, input logic f);
        @(negedge clk);
        valid = v; needs = n; tv = t; mispr = m; mflush = f;
        #1;
    endtask

    task automatic test_reset;
        checks++; if (uv !== 4'h0) begin fails++; $display("FAIL reset_uv: got %h want 0", uv); end
        checks++; if (ut !== {4{7'h40}}) begin fails++; $display("FAIL reset_ut: got %h want %h", ut, {4{7'h40}}); end
        checks++; if (scnt !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0", scnt); end
        checks++; if (iv !== 4'h0) begin fails++; $display("FAIL reset_iv: got %h want 0", iv); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    endtask

    task automatic test_basic_tags;
        drive(4'b1111, 4'b1011, 4'b1111, 0, 0);
        checks++; if (iv !== 4'b0111) begin fails++; $display("FAIL basic_iv: got %b want 0111", iv); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL basic_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        checks++; if (uv !== 4'b1111) begin fails++; $display("FAIL basic_uv: got %b want 1111", uv); end
        checks++; if (ut !== {7'd12, 7'h40, 7'd9, 7'd5}) begin fails++; $display("FAIL basic_ut: got %h want %h", ut, {7'd12, 7'h40, 7'd9, 7'd5}); end
    endtask

    task automatic test_stall;
        drive(4'b0111, 4'b0111, 4'b0011, 0, 0);
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_stall: got %b want 1", stall); end
        checks++; if (iv !== 4'b0000) begin fails++; $display("FAIL stall_iv: got %b want 0000", iv); end
        @(posedge clk); #1;
        checks++; if (scnt !== 16'd1) begin fails++; $display("FAIL stall_cnt: got %0d want 1", scnt); end
        checks++; if (uv !== 4'b0000) begin fails++; $display("FAIL stall_uv: got %b want 0000", uv); end
        drive(4'b0111, 4'b0111, 4'b0111, 0, 0);
        checks++; if (iv !== 4'b0111) begin fails++; $display("FAIL stall_grant_iv: got %b want 0111", iv); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_grant_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        checks++; if (uv !== 4'b0111) begin fails++; $display("FAIL stall_grant_uv: got %b want 0111", uv); end
        checks++; if (ut !== {7'h40, 7'd12, 7'd9, 7'd5}) begin fails++; $display("FAIL stall_grant_ut: got %h want %h", ut, {7'h40, 7'd12, 7'd9, 7'd5}); end
        checks++; if (scnt !== 16'd1) begin fails++; $display("FAIL stall_cnt_hold: got %0d want 1", scnt); end
    endtask

    task automatic test_mispredict;
        logic [6:0] exp_stall;
        exp_stall = 7'b0111110;
        for (int c = 0; c < 7; c++) begin
            drive(c == 0 ? 4'b0000 : 4'b1111, 4'b1111, 4'b1111, c == 0, c < 3);
            checks++; if (stall !== exp_stall[c]) begin fails++; $display("FAIL mispr_stall_c%0d: got %b want %b", c, stall, exp_stall[c]); end
            checks++; if (iv !== (c == 6 ? 4'b1111 : 4'b0000)) begin fails++; $display("FAIL mispr_iv_c%0d: got %b", c, iv); end
        end
        @(posedge clk); #1;
        checks++; if (scnt !== 16'd1) begin fails++; $display("FAIL mispr_cnt: got %0d want 1", scnt); end
        checks++; if (ut !== {7'd20, 7'd12, 7'd9, 7'd5}) begin fails++; $display("FAIL mispr_ut: got %h want %h", ut, {7'd20, 7'd12, 7'd9, 7'd5}); end
    endtask

    task automatic test_mispr_grant;
        drive(4'b0011, 4'b0011, 4'b1111, 0, 0);
        checks++; if (iv !== 4'b0011) begin fails++; $display("FAIL mg_pre_iv: got %b want 0011", iv); end
        @(posedge clk); #1;
        checks++; if (uv !== 4'b0011) begin fails++; $display("FAIL mg_pre_uv: got %b want 0011", uv); end
        drive(4'b0011, 4'b0011, 4'b1111, 1, 0);
        checks++; if (iv !== 4'b0000) begin fails++; $display("FAIL mg_iv: got %b want 0000", iv); end
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL mg_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        checks++; if (uv !== 4'b0000) begin fails++; $display("FAIL mg_uv: got %b want 0000", uv); end
        for (int c = 0; c < 4; c++) drive(4'b0000, 4'b0000, 4'b0000, 0, 0);
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL mg_back_to_run: got %b want 0", stall); end
        checks++; if (scnt !== 16'd2) begin fails++; $display("FAIL mg_cnt: got %0d want 2", scnt); end
    endtask

    task automatic test_notag;
        drive(4'b1111, 4'b0000, 4'b0000, 0, 0);
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL notag_stall: got %b want 0", stall); end
        checks++; if (iv !== 4'b0000) begin fails++; $display("FAIL notag_iv: got %b want 0000", iv); end
        @(posedge clk); #1;
        checks++; if (uv !== 4'b1111) begin fails++; $display("FAIL notag_uv: got %b want 1111", uv); end
        checks++; if (ut !== {4{7'h40}}) begin fails++; $display("FAIL notag_ut: got %h want %h", ut, {4{7'h40}}); end
    endtask

    task automatic test_async_reset;
        drive(4'b1111, 4'b1111, 4'b1111, 0, 0);
        drive(4'b0000, 4'b0000, 4'b1111, 1, 0);
        drive(4'b0000, 4'b0000, 4'b1111, 0, 0);
        drive(4'b0000, 4'b0000, 4'b1111, 0, 0);
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL ar_in_recover: got %b want 1", stall); end
        #2 rst = 1;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL ar_stall: got %b want 0", stall); end
        checks++; if (uv !== 4'b0000) begin fails++; $display("FAIL ar_uv: got %b want 0000", uv); end
        checks++; if (ut !== {4{7'h40}}) begin fails++; $display("FAIL ar_ut: got %h want %h", ut, {4{7'h40}}); end
        checks++; if (scnt !== 16'd0) begin fails++; $display("FAIL ar_cnt: got %0d want 0", scnt); end
        valid = 4'b1111; needs = 4'b1111; tv = 4'b1111;
        #1;
        checks++; if (iv !== 4'b0000) begin fails++; $display("FAIL ar_iv_in_rst: got %b want 0000", iv); end
        @(negedge clk);
        rst = 0; valid = 0; needs = 0; tv = 0;
        #1;
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut.stall_cnt = 16'hFFFD;
        #1 release dut.stall_cnt;
        drive(4'b0111, 4'b0111, 4'b0011, 0, 0);
        @(posedge clk); #1;
        checks++; if (scnt !== 16'hFFFE) begin fails++; $display("FAIL sat_fffe: got %h want fffe", scnt); end
        @(posedge clk); #1;
        checks++; if (scnt !== 16'hFFFF) begin fails++; $display("FAIL sat_ffff: got %h want ffff", scnt); end
        @(posedge clk); #1;
        checks++; if (scnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h want ffff", scnt); end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst = 1; valid = 0; needs = 0; tv = 0; mispr = 0; mflush = 0;
        tags = {6'd20, 6'd12, 6'd9, 6'd5};
        #12;
        test_reset;
        test_basic_tags;
        test_stall;
        test_mispredict;
        test_mispr_grant;
        test_notag;
        test_async_reset;
        test_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rename_tag_ctrl.md
RENAME_TAG_CTRL -- requirements
Module: rename_tag_ctrl

Interface
REQ-001 SHALL have parameter NUM_UOPS, default 4, the rename group width.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2, the post-mispredict quiet cycles before allocation resumes.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port IN_uopValid  input  NUM_UOPS  per-slot uop valid from decode, packed from slot 0.
REQ-006 SHALL have port IN_uopNeedsTag  input  NUM_UOPS  slot writes a register and needs a physical tag.
REQ-007 SHALL have port OUT_stall  output  1  decode must hold its group this cycle.
REQ-008 SHALL have port IN_issueTags  input  NUM_UOPS*6  free-list candidate tags, lowest index first.
REQ-009 SHALL have port IN_issueTagsValid  input  NUM_UOPS  candidate k usable; thermometer-coded.
REQ-010 SHALL have port OUT_issueValid  output  NUM_UOPS  consume free-list candidate k this cycle.
REQ-011 SHALL have port IN_mispr  input  1  branch mispredict, rolls the free list back.
REQ-012 SHALL have port IN_mispredFlush  input  1  in-flight flush window after a mispredict.
REQ-013 SHALL have port OUT_uopValid  output  NUM_UOPS  registered renamed uop valid.
REQ-014 SHALL have port OUT_uopTag  output  NUM_UOPS*7  registered tag per slot; bit 6 set = no tag, bits 5:0 = tag.
REQ-015 SHALL have port OUT_stallCnt  output  16  saturating count of stalled cycles in RUN.

Function
REQ-016 SHALL implement a three-state FSM: RUN, FLUSH, RECOVER.
REQ-017 SHALL go RUN->FLUSH on IN_mispr; FLUSH->RECOVER when IN_mispredFlush and IN_mispr are both low; RECOVER->RUN after RECOVER_CYCLES cycles (counter loaded on entry); any state->FLUSH on IN_mispr, IN_mispr restarting the count.
REQ-018 SHALL compute need = number of slots with IN_uopValid & IN_uopNeedsTag.
REQ-019 SHALL grant the group only in RUN with IN_mispr and IN_mispredFlush low and IN_issueTagsValid[need-1] high (need=0 always grantable); all-or-nothing, no partial groups.
REQ-020 SHALL, on grant, assert OUT_issueValid[k] for k < need only; zero otherwise.
REQ-021 SHALL map slot i needing a tag to candidate k = count of tag-needing valid slots below i; slots not needing a tag get bit 6 set, bits 5:0 zero.
REQ-022 SHALL register the granted group into OUT_uopValid/OUT_uopTag one cycle after grant; OUT_uopValid zero in cycles without grant.
REQ-023 SHALL assert OUT_stall combinationally when any IN_uopValid is set and no grant occurs, and whenever state is not RUN.
REQ-024 SHALL clear OUT_uopValid the cycle after IN_mispr regardless of a grant in the previous cycle.
REQ-025 SHALL increment OUT_stallCnt on cycles in RUN with OUT_stall high, saturating at 16'hFFFF.
REQ-026 SHALL not assert OUT_issueValid while in FLUSH or RECOVER.

Reset
REQ-027 SHALL on rst enter RUN, clear RECOVER counter, OUT_uopValid=0, OUT_uopTag all bit-6-set, OUT_stallCnt=0.
REQ-028 SHALL, with rst asserted mid-group, drop the group; OUT_issueValid=0 while rst high.

Structure
REQ-029 SHALL place the FSM state enum, tag width (6) and no-tag bit index (6) in the shared package.
REQ-030 SHALL factor the per-slot prefix count (REQ-021) into one sub-module, tag_slot_compact.

Verification
REQ-031 SHALL test: valid=1111, needsTag=1011, tagsValid=1111, tags 5,9,12,20 -> issueValid=0111; next cycle tags slot0=5, slot1=9, slot2=no-tag(bit6), slot3=12.
REQ-032 SHALL test: need=3, tagsValid=0011 -> OUT_stall=1, issueValid=0000, stallCnt+1; tagsValid->0111 next cycle -> grant.
REQ-033 SHALL test: IN_mispr pulse, mispredFlush high 3 cycles -> stall in FLUSH; RUN exactly RECOVER_CYCLES=2 cycles after flush drops.
REQ-034 SHALL test: IN_mispr in grant cycle -> no issueValid that cycle, OUT_uopValid=0 next cycle.
REQ-035 SHALL test: needsTag=0000, valid=1111, tagsValid=0000 -> granted, all tags bit-6-set.
REQ-036 SHALL test: rst asserted asynchronously mid-RECOVER -> immediate RUN, outputs at reset values; stallCnt saturation at FFFF after forced preload.
